// File: rtl/mem_copy_engine_pkg.sv
// Shared constants, FSM state type and port-mode encodings for the copy engine.
// MEM_COPY_VERIFY_EN adds the readback states VRD and VCHK.
package mem_copy_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  localparam logic MODE_PORT_A = 1'b0;
  localparam logic MODE_PORT_B = 1'b1;

`ifdef MEM_COPY_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    VRD  = 3'd3,
    VCHK = 3'd4,
    DONE = 3'd5
  } copy_state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd5
  } copy_state_t;
`endif

endpackage

// File: rtl/mem_copy_engine_if.sv
// Pin bundle between the copy engine (master) and the 32x32 dual-port memory (slave).
interface mem_copy_engine_if #(
  parameter int DATA_W = mem_copy_pkg::DATA_W
);
  logic [DATA_W-1:0] data_in;
  logic [31:0]       addr_a;
  logic [31:0]       addr_b;
  logic              mode;
  logic              wr_en;
  logic [DATA_W-1:0] data_out;

  modport master (output data_in, addr_a, addr_b, mode, wr_en, input data_out);
  modport slave  (input data_in, addr_a, addr_b, mode, wr_en, output data_out);
endinterface

// File: rtl/mem_copy_engine.sv
// Block-copy controller: reads each word on port B, writes it on port A, ascending.
// Define MEM_COPY_VERIFY_EN to add a readback compare per word with a sticky err flag.
module mem_copy_engine #(
  parameter int DATA_W = mem_copy_pkg::DATA_W,
  parameter int ADDR_W = mem_copy_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  mem_copy_engine_if.master mem
);
  import mem_copy_pkg::*;

  localparam int              PAD_W   = 32 - ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  // Natural ADDR_W-bit overflow gives the required modulo-32 wrap.
  assign rd_addr = src_q + idx_q;
  assign wr_addr = dst_q + idx_q;

`ifdef MEM_COPY_VERIFY_EN
  logic [DATA_W-1:0] word_q, word_d;
  logic              err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      last_q  <= '0;
`ifdef MEM_COPY_VERIFY_EN
      word_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      last_q  <= last_d;
`ifdef MEM_COPY_VERIFY_EN
      word_q  <= word_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    src_d       = src_q;
    dst_d       = dst_q;
    last_d      = last_q;
`ifdef MEM_COPY_VERIFY_EN
    word_d      = word_q;
    err_d       = err_q;
`endif
    mem.mode    = MODE_PORT_B;
    mem.addr_a  = '0;
    mem.addr_b  = '0;
    mem.wr_en   = 1'b0;
    mem.data_in = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d = src_base_i;
          dst_d = dst_base_i;
          idx_d = '0;
`ifdef MEM_COPY_VERIFY_EN
          err_d = 1'b0;
`endif
          if (len_i == '0) begin
            state_d = DONE;
          end else begin
            // Store N-1 so a saturated length of 32 still fits in ADDR_W bits.
            last_d  = (len_i >= MAX_LEN) ? '1 : len_i[ADDR_W-1:0] - ADDR_W'(1);
            state_d = RD;
          end
        end
      end
      RD: begin
        mem.addr_b = {{PAD_W{1'b0}}, rd_addr};
        state_d    = WR;
      end
      WR: begin
        mem.mode    = MODE_PORT_A;
        mem.addr_a  = {{PAD_W{1'b0}}, wr_addr};
        mem.wr_en   = ~rst;
        mem.data_in = mem.data_out;
`ifdef MEM_COPY_VERIFY_EN
        word_d  = mem.data_out;
        state_d = VRD;
`else
        if (idx_q == last_q) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = RD;
        end
`endif
      end
`ifdef MEM_COPY_VERIFY_EN
      VRD: begin
        mem.addr_b = {{PAD_W{1'b0}}, wr_addr};
        state_d    = VCHK;
      end
      VCHK: begin
        if (mem.data_out != word_q) err_d = 1'b1;
        if (idx_q == last_q) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = RD;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural 32x32 dual-port memory.
// Honours MEM_COPY_VERIFY_EN for cycle counts and the stuck-bit readback test.
module tb_mem_copy_engine;

`ifdef MEM_COPY_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] src_base = '0;
  logic [4:0] dst_base = '0;
  logic [5:0] len = '0;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  mem_copy_engine_if #(.DATA_W(32)) mif ();

  mem_copy_engine #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .src_base_i (src_base),
    .dst_base_i (dst_base),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .mem        (mif)
  );

  always #5 clk = ~clk;

  // Memory model: port A write, port B registered read, optional stuck bit 31 on word 5.
  logic [31:0] mem [32];
  logic [31:0] exp_mem [32];
  logic        pre_req = 1'b0;
  logic        stuck_en = 1'b0;
  int          wr_cnt = 0;

  function automatic logic [31:0] fpat(input int a);
    return 32'h11 * (a + 1);
  endfunction

  always @(posedge clk) begin
    if (pre_req) begin
      for (int a = 0; a < 32; a++) mem[a] <= fpat(a);
    end else if (!mif.mode && mif.wr_en) begin
      mem[mif.addr_a[4:0]] <= mif.data_in |
        ((stuck_en && mif.addr_a[4:0] == 5'd5) ? 32'h8000_0000 : 32'h0);
      wr_cnt <= wr_cnt + 1;
    end
    if (mif.mode) mif.data_out <= mem[mif.addr_b[4:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_preload();
    pre_req = 1'b1;
    step();
    pre_req = 1'b0;
    for (int a = 0; a < 32; a++) exp_mem[a] = fpat(a);
  endtask

  task automatic exp_copy(input logic [4:0] s, input logic [4:0] d, input int n);
    logic [4:0] k;
    for (int j = 0; j < n; j++) begin
      k = 5'(j);
      exp_mem[d + k] = exp_mem[s + k];
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int a = 0; a < 32; a++) chk($sformatf("%s_mem%0d", tag, a), mem[a], exp_mem[a]);
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_wr_en"}, mif.wr_en, 1'b0);
    chk({tag, "_mode"}, mif.mode, 1'b1);
    chk({tag, "_addr_a"}, mif.addr_a, 32'h0);
    chk({tag, "_addr_b"}, mif.addr_b, 32'h0);
    chk({tag, "_data_in"}, mif.data_in, 32'h0);
  endtask

  typedef struct {
    logic [4:0] src;
    logic [4:0] dst;
    logic [5:0] len;
    bit         pre;
    int         n;
    int         done2;
    int         done4;
    int         poke;
  } vec_t;

  // Starts a copy in the current (idle) cycle and follows it to the first idle cycle after done.
  task automatic run_copy(input string tag, input vec_t v);
    int cyc, w0;
    bit busy_ok, pins_ok;
    if (v.pre) do_preload();
    w0 = wr_cnt;
    start = 1'b1; src_base = v.src; dst_base = v.dst; len = v.len;
    step();
    start = 1'b0;
    cyc = 1; busy_ok = 1'b1; pins_ok = 1'b1;
    while (!done && cyc < 300) begin
      if (!busy) busy_ok = 1'b0;
      if (!(mif.wr_en && !mif.mode) && mif.data_in != 32'h0) pins_ok = 1'b0;
      if (mif.addr_a[31:5] != 27'h0 || mif.addr_b[31:5] != 27'h0) pins_ok = 1'b0;
      if (cyc == v.poke) begin
        start = 1'b1; src_base = 5'd8; dst_base = 5'd24; len = 6'd2;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, VFY ? v.done4 : v.done2);
    chk({tag, "_busy_at_done"}, busy, 1'b1);
    chk({tag, "_busy_throughout"}, busy_ok, 1'b1);
    chk({tag, "_pins"}, pins_ok, 1'b1);
    chk({tag, "_err"}, err, 1'b0);
    step();
    chk_idle_pins({tag, "_after"});
    chk({tag, "_writes"}, wr_cnt - w0, v.n);
    exp_copy(v.src, v.dst, v.n);
    chk_mem(tag);
  endtask

  // Reset asserted in cycle rcyc of a len=8 copy from 0 to 16; words 0-1 must be the only writes.
  task automatic rst_mid(input string tag, input int rcyc);
    int w0;
    do_preload();
    w0 = wr_cnt;
    start = 1'b1; src_base = 5'd0; dst_base = 5'd16; len = 6'd8;
    step();
    start = 1'b0;
    for (int c = 1; c < rcyc; c++) step();
    rst = 1'b1;
    #1;
    chk({tag, "_wr_en_gated"}, mif.wr_en, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_writes"}, wr_cnt - w0, 2);
    exp_copy(5'd0, 5'd16, 2);
    chk_mem(tag);
  endtask

  vec_t vecs[10];

  initial begin
    //           src    dst    len    pre  n   d2  d4  poke
    vecs[0] = '{5'd0,  5'd16, 6'd4,  1, 4,  9,  17, 0};   // basic
    vecs[1] = '{5'd16, 5'd24, 6'd4,  0, 4,  9,  17, 0};   // back-to-back, no preload gap
    vecs[2] = '{5'd30, 5'd2,  6'd4,  1, 4,  9,  17, 0};   // source wrap
    vecs[3] = '{5'd5,  5'd20, 6'd0,  1, 0,  1,  1,  0};   // zero length
    vecs[4] = '{5'd7,  5'd7,  6'd40, 1, 32, 65, 129, 0};  // saturate, in place
    vecs[5] = '{5'd9,  5'd0,  6'd63, 1, 32, 65, 129, 0};  // saturate, destructive wrap
    vecs[6] = '{5'd10, 5'd12, 6'd1,  1, 1,  3,  5,  0};   // single word
    vecs[7] = '{5'd1,  5'd31, 6'd2,  1, 2,  5,  9,  0};   // destination wrap
    vecs[8] = '{5'd0,  5'd16, 6'd4,  1, 4,  9,  17, 3};   // start pulsed while busy
    vecs[9] = '{5'd0,  5'd0,  6'd32, 1, 32, 65, 129, 0};  // exact 32

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_idle_pins("reset");
    chk("reset_err", err, 1'b0);

    for (int v = 0; v < 10; v++) run_copy($sformatf("vec%0d", v), vecs[v]);

    // Forward overlap: destructive ascending copy replicates the first word.
    run_copy("overlap", '{5'd0, 5'd1, 6'd3, 1, 3, 7, 13, 0});
    chk("overlap_m0", mem[0], 32'h11);
    chk("overlap_m1", mem[1], 32'h11);
    chk("overlap_m2", mem[2], 32'h11);
    chk("overlap_m3", mem[3], 32'h11);
    chk("overlap_m4", mem[4], 32'h55);

    rst_mid("rst_rd", VFY ? 9 : 5);
    rst_mid("rst_wr", VFY ? 10 : 6);
    run_copy("post_rst", vecs[0]);

`ifdef MEM_COPY_VERIFY_EN
    begin
      int cyc;
      do_preload();
      stuck_en = 1'b1;
      start = 1'b1; src_base = 5'd0; dst_base = 5'd3; len = 6'd4;
      step();
      start = 1'b0;
      cyc = 1;
      while (cyc < 12) begin step(); cyc++; end
      chk("vfy_err_before", err, 1'b0);
      step(); cyc++;
      chk("vfy_err_set", err, 1'b1);
      while (!done && cyc < 60) begin step(); cyc++; end
      chk("vfy_done_cycle", cyc, 17);
      chk("vfy_err_at_done", err, 1'b1);
      step();
      chk("vfy_err_held", err, 1'b1);
      chk("vfy_mem5", mem[5], 32'h8000_0033);
      stuck_en = 1'b0;
      start = 1'b1; src_base = 5'd0; dst_base = 5'd16; len = 6'd1;
      step();
      start = 1'b0;
      chk("vfy_err_cleared", err, 1'b0);
      cyc = 1;
      while (!done && cyc < 60) begin step(); cyc++; end
      chk("vfy2_done_cycle", cyc, 5);
      chk("vfy2_err", err, 1'b0);
      step();
      chk("vfy2_mem16", mem[16], 32'h11);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Initiator-side controller for the 32×32 dual-port word memory. Accepts a block-copy command (source base, destination base, length) and drives the memory's `data_in`/`addr_a`/`addr_b`/`mode`/`wr_en` pins. Each word is read through port B (`mode=1`) and written through port A (`mode=0`, `wr_en=1`). It sits between control logic and the memory, and is the only master of the memory pins.

## Interface
Parameters:
- DATA_W, 32, memory word width
- ADDR_W, 5, internal address width; the memory holds 2^ADDR_W = 32 words

Ports:
- clk  in  1  single clock; all logic updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  command strobe; sampled only in IDLE
- src_base  in  ADDR_W  first source word address
- dst_base  in  ADDR_W  first destination word address
- len  in  ADDR_W+1  word count; 0 is allowed; 33–63 saturate to 32
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse when the copy completes
- err  out  1  sticky readback mismatch; tied 0 without the macro
- mem_data_in  out  DATA_W  to memory `data_in`
- mem_addr_a  out  32  write address, zero-extended from ADDR_W
- mem_addr_b  out  32  read address, zero-extended from ADDR_W
- mem_mode  out  1  0 = port A access, 1 = port B read
- mem_wr_en  out  1  memory write enable
- mem_data_out  in  DATA_W  registered memory output; valid the cycle after the address is sampled

## Operation
- **FSM states:** IDLE, RD, WR, VRD, VCHK, DONE. VRD and VCHK exist only with the macro.
- **Start, IDLE:**
  - `start` with effective len N ≥ 1: latch src, dst and N, clear word index i, clear err, go to RD.
  - `start` with N = 0: go to DONE; no memory access.
- **RD:** `mem_mode=1`, `mem_addr_b=src+i`, `mem_wr_en=0`. Next state is WR.
- **WR:**
  - `mem_mode=0`, `mem_addr_a=dst+i`, `mem_wr_en=1`.
  - `mem_data_in=mem_data_out` (combinational pass-through); the word is also captured in `word_q`.
  - Next state: VRD if verify is enabled; otherwise RD with i+1, or DONE when i = N−1.
- **VRD:** `mem_mode=1`, `mem_addr_b=dst+i`. Next state is VCHK.
- **VCHK:** if `mem_data_out != word_q`, set err. Then go to RD with i+1, or to DONE when i = N−1.
- **DONE:** `done=1`, `busy=1`, next state IDLE.
- **Address arithmetic:** src+i and dst+i are computed modulo 32. Wrap-around from 31 to 0 is legal and required.
- **Overlap:** the copy is strictly ascending and word-by-word. With dst in (src, src+N) the copy is destructive (already-written words get re-read); this is the defined behaviour, not an error.
- **Busy:** `start` while busy is ignored. Inputs are not re-sampled mid-copy.
- **Idle pin values:** `mem_mode=1`, both addresses 0, `mem_wr_en=0`, `mem_data_in=0`. In non-WR states `mem_data_in=0`.
- **Reset mid-copy:**
  - `mem_wr_en` is gated by ~rst combinationally, so no write is issued in the reset cycle.
  - After the edge: state IDLE; `busy`, `done` and `err` are 0; `i` is 0.

## Timing
- **Reset values:** `busy=0`, `done=0`, `err=0`, `mem_wr_en=0`, `mem_mode=1`, `mem_addr_a=0`, `mem_addr_b=0`, `mem_data_in=0`.
- **Cycle numbering:** cycle 1 is the cycle after the edge that samples `start`.
- **Per-word cost:** 2 cycles (RD, WR); 4 with verify (RD, WR, VRD, VCHK).
- **done:** high in cycle 2N+1 (4N+1 with verify); for N = 0, in cycle 1.
- **busy:** high from cycle 1 through the done cycle inclusive.
- **Back-to-back:** a new `start` is accepted in the cycle after the done cycle.
- **Memory read latency:** fixed at exactly 1 cycle; no stalls and no backpressure.

## Configuration
- **MEM_COPY_VERIFY_EN defined:**
  - VRD and VCHK states are built in, giving 4 cycles per word.
  - `err` goes high one cycle after the first mismatching VCHK and stays high until the next accepted `start` or `rst`.
- **Not defined:** 2 cycles per word, `err` tied to 0, and no `word_q` compare logic.

## Structure
- **Package `mem_copy_pkg`:**
  - constants DATA_W=32, ADDR_W=5, DEPTH=32;
  - the state enum `copy_state_t`;
  - encodings MODE_PORT_A=0 and MODE_PORT_B=1.
- **No sub-module:** a single module holding the FSM, index counter and output decode.
- **Verification:** benches instantiate the memory model alongside this block.

## Test plan
- **Basic copy:** preload mem[0..3]=0x11,0x22,0x33,0x44; start with src=0, dst=16, len=4 -> mem[16..19] match; done in cycle 9 (17 with verify); mem[0..3] unchanged.
- **Wrap-around:** src=30, dst=2, len=4 -> mem[2..5] = old mem[30], mem[31], mem[0], mem[1].
- **len=0 and len=40:**
  - len=0 -> done in cycle 1 and `mem_wr_en` never high.
  - len=40 -> exactly 32 writes.
- **Ignored start and reset mid-copy:**
  - `start` pulsed during busy -> ignored; exactly N writes observed.
  - `rst` in cycle 5 of a len=8 copy -> only words 0–1 written; `mem_wr_en=0` in the reset cycle; `busy=0` after.
- **Forward overlap:** mem[0..3]=A,B,C,D; src=0, dst=1, len=3 -> mem[1..3]=A,A,A.
- **Verify (MEM_COPY_VERIFY_EN):** force a stuck bit on dst word 5 in the model -> `err=1` after that VCHK, held through done; cleared by the next `start`.
